// File: rtl/sn76489_pkg.sv
// Shared types and constants for the SN76489 tone and noise channels.
package sn76489_pkg;

  typedef logic [9:0] freq_t;
  typedef logic [3:0] att_t;

  typedef enum logic {
    REG_FREQ = 1'b0,
    REG_ATT  = 1'b1
  } reg_type_e;

  // 2 dB attenuation steps; index 15 is silence.
  localparam logic [15:0][7:0] ATT_TABLE = {
    8'd0,   8'd10,  8'd13,  8'd16,  8'd20,  8'd26,  8'd32,  8'd40,
    8'd51,  8'd64,  8'd81,  8'd102, 8'd128, 8'd161, 8'd203, 8'd255
  };

endpackage

// File: rtl/sn76489_attenuator.sv
// Registered amplitude: full table level while the tone bit is high, else 0.
// One cycle latency from tone/att to ampl_o; shared by tone and noise channels.
module sn76489_attenuator
  import sn76489_pkg::*;
(
  input  logic       clock_i,
  input  logic       res_i,
  input  logic       tone,
  input  logic [3:0] att,
  output logic [7:0] ampl_o
);

  logic [7:0] ampl_q, ampl_d;

  always_comb begin
    ampl_d = 8'd0;
    if (tone) ampl_d = ATT_TABLE[att];
  end

  always_ff @(posedge clock_i or posedge res_i) begin
    if (res_i) ampl_q <= 8'd0;
    else       ampl_q <= ampl_d;
  end

  assign ampl_o = ampl_q;

endmodule

// File: rtl/sn76489_tone.sv
// SN76489 square-wave tone channel: write decode, 10-bit half-period counter, attenuated output.
// SN76489_TONE_DC_EN: freq 0/1 holds the tone bit high (DC output) while the counter keeps running.
module sn76489_tone
  import sn76489_pkg::*;
#(
  parameter int chan_g = 0
) (
  input  logic       clock_i,
  input  logic       res_i,
  input  logic       clk_en_i,
  input  logic       we_i,
  input  logic [7:0] d_i,
  output logic       tone_o,
  output logic [7:0] ampl_o
);

  localparam logic [1:0] CHAN = 2'(chan_g);

  freq_t     freq_q, freq_d;
  att_t      att_q, att_d;
  freq_t     cnt_q, cnt_d;
  logic      tone_q, tone_d;
  logic      sel_q, sel_d;
  reg_type_e type_q, type_d;

  always_comb begin
    freq_d = freq_q;
    att_d  = att_q;
    cnt_d  = cnt_q;
    tone_d = tone_q;
    sel_d  = sel_q;
    type_d = type_q;

    if (we_i) begin
      if (d_i[7]) begin
        // Latch bytes for other channels still deselect us.
        sel_d  = (d_i[6:5] == CHAN);
        type_d = reg_type_e'(d_i[4]);
        if (d_i[6:5] == CHAN) begin
          if (d_i[4] == REG_FREQ) freq_d[3:0] = d_i[3:0];
          else                    att_d       = d_i[3:0];
        end
      end else if (sel_q) begin
        if (type_q == REG_FREQ) freq_d[9:4] = d_i[5:0];
        else                    att_d       = d_i[3:0];
      end
    end

    // Reload uses the pre-write period; freq 0 wraps to a 1024-tick half-period.
    if (clk_en_i) begin
      if (cnt_q == 10'd0) begin
        cnt_d  = freq_q - 10'd1;
        tone_d = ~tone_q;
      end else begin
        cnt_d  = cnt_q - 10'd1;
      end
    end

`ifdef SN76489_TONE_DC_EN
    if (freq_q <= 10'd1) tone_d = 1'b1;
`endif
  end

  always_ff @(posedge clock_i or posedge res_i) begin
    if (res_i) begin
      freq_q <= '0;
      att_q  <= 4'hF;
      cnt_q  <= '0;
      tone_q <= 1'b0;
      sel_q  <= 1'b0;
      type_q <= REG_FREQ;
    end else begin
      freq_q <= freq_d;
      att_q  <= att_d;
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
      sel_q  <= sel_d;
      type_q <= type_d;
    end
  end

  sn76489_attenuator u_att (
    .clock_i (clock_i),
    .res_i   (res_i),
    .tone    (tone_q),
    .att     (att_q),
    .ampl_o  (ampl_o)
  );

  assign tone_o = tone_q;

endmodule

// File: doc/sn76489_tone.md
# sn76489_tone

Single square-wave tone channel of the SN76489AN sound generator. Sits directly downstream of the clock divider and consumes its clock-enable pulse as the channel's time base. Decodes the chip's byte-wide write protocol for its own channel, runs a 10-bit half-period counter, and produces a tone bit plus an attenuated 8-bit amplitude for the mixer. Three instances (`chan_g` = 0..2) make up the tone section.

## Interface
- `chan_g`, default 0: channel index 0..2, matched against write-byte bits [6:5].
- `clock_i`  in  1  system clock.
- `res_i`  in  1  reset, asynchronous, active-high.
- `clk_en_i`  in  1  tick from the clock divider, one cycle wide.
- `we_i`  in  1  register write strobe, one cycle wide, independent of `clk_en_i`.
- `d_i`  in  8  write data byte.
- `tone_o`  out  1  current tone flip-flop state.
- `ampl_o`  out  8  unsigned amplitude, 0 when tone low or attenuation 15.

## Operation
- Latch byte (`we_i` and `d_i[7]`=1):
  - always records `sel_q` = (`d_i[6:5]`==`chan_g`) and `type_q` = `d_i[4]`, even for other channels; a non-match clears `sel_q`.
  - on match: `type`=0 writes `freq_q[3:0]`=`d_i[3:0]`; `type`=1 writes `att_q`=`d_i[3:0]`.
- Data byte (`we_i` and `d_i[7]`=0), applied only when `sel_q`=1:
  - `type_q`=0 writes `freq_q[9:4]`=`d_i[5:0]`.
  - `type_q`=1 writes `att_q`=`d_i[3:0]`.
  - `sel_q`/`type_q` are unchanged, so repeated data bytes keep hitting the same register.
- Counter, on `clk_en_i` only:
  - `cnt_q`==0: reload `cnt_q`=`freq_q`-1 (10-bit wrap) and toggle `tone_q`.
  - otherwise `cnt_q`-1.
  - Half-period is `freq_q` ticks; `freq_q`=0 gives 1024 ticks.
- Writes never reset `cnt_q` or `tone_q`. A new period takes effect at the next reload.
- Amplitude: `ampl_o` is registered every clock as `tone_q` ? `ATT_TABLE[att_q]` : 0.
  - `ATT_TABLE` (2 dB steps): 255,203,161,128,102,81,64,51,40,32,26,20,16,13,10,0.

## Timing
- Reset values: `freq_q`=0, `att_q`=15, `cnt_q`=0, `tone_q`=0, `sel_q`=0, `type_q`=0; `tone_o`=0, `ampl_o`=0.
- Register writes are visible the cycle after `we_i`.
- `tone_o` changes the cycle after the reloading `clk_en_i`. `ampl_o` follows `tone_o` with one further cycle of latency.
- `we_i` and `clk_en_i` in the same cycle: the counter reload uses the pre-write `freq_q`; the write still completes.
- `clk_en_i` low: the counter and tone hold; writes still act.
- Reset asserted mid-period: all state returns to reset values immediately, no glitch gating.

## Configuration
- `SN76489_TONE_DC_EN` defined:
  - when `freq_q` is 0 or 1, `tone_q` is forced to 1 and does not toggle, giving DC output at the attenuated level (Sega VDP variant).
  - the counter keeps running.
- Undefined: `freq_q`=1 toggles on every tick, and `freq_q`=0 gives 1024-tick half-periods as above.

## Structure
- Package `sn76489_pkg` holds:
  - `ATT_TABLE` constant (16×8-bit);
  - typedef `freq_t` (10-bit), `att_t` (4-bit);
  - enum `reg_type_e` {`REG_FREQ`, `REG_ATT`}.
- One sub-module, `sn76489_attenuator`: inputs `clock_i`, `res_i`, `tone`, `att`; output registered `ampl_o`. It is shared with the noise channel.
- Register decode and the counter stay in the top module.

## Test plan
- Reset: hold `res_i` 3 cycles -> `tone_o`=0, `ampl_o`=0; toggle `clk_en_i` 100 times with no writes -> `tone_o` toggles every 1024 ticks, `ampl_o` stays 0 (att=15).
- Channel 1, write 0xA5 then 0x01 -> `freq_q`=0x015; write 0xB0 -> att 0; with `clk_en_i` every cycle -> `tone_o` toggles every 21 ticks after the first reload; `ampl_o`=255 while high, 0 while low.
- Foreign channel: chan_g=0, write 0xA3 then 0x3F -> `freq_q` of channel 0 unchanged (`sel_q` cleared).
- Data to attenuation: write 0x90 then 0x07 -> `att_q`=7; `ampl_o` high level = 51.
- Collision: `freq_q`=4 and `cnt_q`=0 with `we_i` data byte in the same cycle as `clk_en_i` -> reload uses 3 (old value); the next reload uses the new value.
- `SN76489_TONE_DC_EN`: write freq=1, att=0 -> `tone_o`=1 constant, `ampl_o`=255 constant; without the macro -> `tone_o` toggles every tick.
